// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned-access detection).
package mem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DATA_W     = 32;

    // One slot of the read-response pipeline.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              err;
    } resp_stage_t;

    // Byte address to word address; callers truncate to their RAM index width.
    function automatic logic [63:0] widx(input logic [63:0] addr);
        return addr >> $clog2(WORD_BYTES);
    endfunction

endpackage

// File: rtl/dmem_resp_pipe.sv
// Fixed-latency read-response shift register with flush-clear.
// Payload only loads alongside a valid bit, so the output holds its last data while idle.
module dmem_resp_pipe
    import mem_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  resp_stage_t stage_i,
    output resp_stage_t stage_o
);

    resp_stage_t stage_q [READ_LATENCY];

    // Shift responses one stage per cycle; flush clears every valid bit incl. the incoming one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0].valid <= stage_i.valid & ~flush_i;
            if (stage_i.valid) begin
                stage_q[0].data <= stage_i.data;
                stage_q[0].err  <= stage_i.err;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                stage_q[k].valid <= stage_q[k-1].valid & ~flush_i;
                if (stage_q[k-1].valid) begin
                    stage_q[k].data <= stage_q[k-1].data;
                    stage_q[k].err  <= stage_q[k-1].err;
                end
            end
        end
    end

    assign stage_o = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the write-back stage: word RAM, retire-time store port,
// write-first read bypass and a fixed-latency response pipeline with flush-kill.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (flags and suppresses misaligned accesses).
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  mem_rd_en,
    input  logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rdata_valid,
    input  logic                  mem_write_en,
    input  logic [ADDR_WIDTH-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_err
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    logic [DATA_WIDTH-1:0] ram_q [DEPTH_WORDS];
    logic [IdxW-1:0]       ridx;
    logic [IdxW-1:0]       widx_w;
    logic                  rd_mis;
    logic                  wr_mis;
    logic                  we_eff;
    logic [DATA_WIDTH-1:0] rd_word;
    resp_stage_t           stage_in;
    resp_stage_t           stage_out;

    // Upper address bits beyond the RAM index are dropped, so addresses wrap.
    assign ridx   = IdxW'(widx(64'(mem_raddr)));
    assign widx_w = IdxW'(widx(64'(mem_waddr)));

`ifdef DMEM_ALIGN_CHECK_EN
    assign rd_mis = (mem_raddr[1:0] != 2'b00);
    assign wr_mis = (mem_waddr[1:0] != 2'b00);
`else
    assign rd_mis = 1'b0;
    assign wr_mis = 1'b0;
`endif

    // Misaligned stores never reach the array.
    assign we_eff = mem_write_en & ~wr_mis;

    // Store port; retired stores ignore flush.
    always_ff @(posedge clk) begin
        if (we_eff) begin
            ram_q[widx_w] <= mem_wdata;
        end
    end

    // Build the issue-stage entry; a same-cycle store to the same word wins (write-first).
    always_comb begin
        rd_word        = (we_eff && (widx_w == ridx)) ? mem_wdata : ram_q[ridx];
        stage_in       = '0;
        stage_in.valid = mem_rd_en;
        stage_in.data  = rd_mis ? '0 : rd_word;
        stage_in.err   = rd_mis;
    end

    dmem_resp_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_resp_pipe (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (flush),
        .stage_i (stage_in),
        .stage_o (stage_out)
    );

    assign mem_rdata       = stage_out.data;
    assign mem_rdata_valid = stage_out.valid;

`ifdef DMEM_ALIGN_CHECK_EN
    logic wr_err_q;

    // Misaligned-store error shows one cycle after the store edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= mem_write_en & wr_mis;
        end
    end

    // Read and write errors merge into a single pulse.
    assign mem_err = wr_err_q | (stage_out.valid & stage_out.err);
`else
    logic unused_err;
    assign unused_err = stage_out.err;
    assign mem_err    = 1'b0;
`endif

endmodule
